// File: rtl/wb_router_pkg.sv
// Shared types and constants for the Wishbone address router.
// Holds the FSM state encoding, bus widths, the default error word and a clog2 helper.
package wb_router_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 32;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DBG  = 2'd1,
      ST_FWD  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Ceiling log2 for elaboration-time sizing; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < 32'(value)) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_router_dbg_regs.sv
// Debug register bank for the router: DEPTH 32-bit registers with
// byte-enable writes and a combinational indexed read port.
module wb_router_dbg_regs
   import wb_router_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    idx,
   input  logic [3:0]       sel,
   input  logic [WB_DW-1:0] wdata,
   output logic [WB_DW-1:0] rdata
);

   logic [WB_DW-1:0] regs_r [DEPTH];

   // Register storage: cleared on reset, byte-lane writes otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_r[k] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
               regs_r[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = regs_r[idx];

endmodule

// File: rtl/wb_addr_router.sv
// Wishbone address router: one slave port fanned out to N_CH user channels plus a
// debug register bank at the top of the window. Optional watchdog: WB_ROUTER_TIMEOUT_EN.
module wb_addr_router
   import wb_router_pkg::*;
#(
   parameter int          N_CH       = 4,
   parameter logic [31:0] WIN_BASE   = 32'h3000_0000,
   parameter int          WIN_BITS   = 20,
   parameter int          DEBUG_REGS = 2,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [WB_AW-1:0]      wbs_adr_i,
   input  logic [WB_DW-1:0]      wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [WB_DW-1:0]      wbs_dat_o,
   output logic [N_CH-1:0]       s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic [WB_AW-1:0]      s_adr_o,
   output logic [WB_DW-1:0]      s_dat_o,
   input  logic [N_CH-1:0]       s_ack_i,
   input  logic [WB_DW*N_CH-1:0] s_dat_i,
   output logic                  timeout_o
);

   localparam int CH_W   = (N_CH > 1) ? clog2(N_CH) : 1;
   localparam int DBG_AW = clog2(DEBUG_REGS);

   state_t             state_r, state_nxt;
   logic [N_CH-1:0]    cyc_r, cyc_nxt;
   logic               stb_r, stb_nxt;
   logic               we_r, we_nxt;
   logic [3:0]         sel_r, sel_nxt;
   logic [WB_AW-1:0]   adr_r, adr_nxt;
   logic [WB_DW-1:0]   wdat_r, wdat_nxt;
   logic               ack_r, ack_nxt;
   logic [WB_DW-1:0]   rdat_r, rdat_nxt;
   logic               tmo_r, tmo_nxt;
   logic [CH_W-1:0]    ch_r, ch_nxt;
   logic [DBG_AW-1:0]  idx_r, idx_nxt;
`ifdef WB_ROUTER_TIMEOUT_EN
   logic [15:0]        cnt_r, cnt_nxt;
`endif

   logic               win_hit_s;
   logic               dbg_hit_s;
   logic [DBG_AW-1:0]  dbg_idx_s;
   logic [CH_W-1:0]    ch_s;
   logic               slv_ack_s;
   logic               dbg_wr_s;
   logic [WB_DW-1:0]   dbg_rdata_s;
   logic [WB_DW-1:0]   slv_dat_s [N_CH];

   assign win_hit_s = (wbs_adr_i[WB_AW-1:WIN_BITS] == WIN_BASE[WB_AW-1:WIN_BITS]);
   assign dbg_hit_s = win_hit_s && (&wbs_adr_i[WIN_BITS-1:2+DBG_AW]);
   assign dbg_idx_s = wbs_adr_i[2+DBG_AW-1:2];

   if (N_CH > 1) begin : g_ch_dec
      assign ch_s = wbs_adr_i[WIN_BITS-1 -: CH_W];
   end else begin : g_ch_one
      assign ch_s = 1'b0;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_slv_dat
      assign slv_dat_s[k] = s_dat_i[WB_DW*k +: WB_DW];
   end

   assign slv_ack_s = s_ack_i[ch_r];

   wb_router_dbg_regs #(
      .DEPTH (DEBUG_REGS),
      .AW    (DBG_AW)
   ) u_dbg_regs (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .wr_en (dbg_wr_s),
      .idx   (idx_r),
      .sel   (sel_r),
      .wdata (wdat_r),
      .rdata (dbg_rdata_s)
   );

   // Next-state and next-output logic for the request/response sequence.
   always_comb begin
      state_nxt = state_r;
      cyc_nxt   = cyc_r;
      stb_nxt   = stb_r;
      we_nxt    = we_r;
      sel_nxt   = sel_r;
      adr_nxt   = adr_r;
      wdat_nxt  = wdat_r;
      ack_nxt   = 1'b0;
      rdat_nxt  = rdat_r;
      tmo_nxt   = 1'b0;
      ch_nxt    = ch_r;
      idx_nxt   = idx_r;
      dbg_wr_s  = 1'b0;
`ifdef WB_ROUTER_TIMEOUT_EN
      cnt_nxt   = cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i && win_hit_s) begin
               we_nxt   = wbs_we_i;
               sel_nxt  = wbs_sel_i;
               adr_nxt  = wbs_adr_i;
               wdat_nxt = wbs_dat_i;
               idx_nxt  = dbg_idx_s;
               ch_nxt   = ch_s;
               if (dbg_hit_s) begin
                  state_nxt = ST_DBG;
                  stb_nxt   = 1'b0;
               end else begin
                  state_nxt = ST_FWD;
                  stb_nxt   = 1'b1;
                  for (int k = 0; k < N_CH; k++) begin
                     cyc_nxt[k] = (CH_W'(k) == ch_s);
                  end
`ifdef WB_ROUTER_TIMEOUT_EN
                  cnt_nxt = 16'd0;
`endif
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DBG: begin
            if (!wbs_cyc_i) begin
               state_nxt = ST_IDLE;
               we_nxt    = 1'b0;
               sel_nxt   = 4'h0;
               adr_nxt   = '0;
               wdat_nxt  = '0;
            end else begin
               dbg_wr_s = we_r;
               if (we_r) begin
                  rdat_nxt = rdat_r;
               end else begin
                  rdat_nxt = dbg_rdata_s;
               end
               ack_nxt   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_FWD: begin
            if (!wbs_cyc_i) begin
               state_nxt = ST_IDLE;
               cyc_nxt   = '0;
               stb_nxt   = 1'b0;
               we_nxt    = 1'b0;
               sel_nxt   = 4'h0;
               adr_nxt   = '0;
               wdat_nxt  = '0;
            end else if (slv_ack_s) begin
               // Slave ack beats a watchdog expiry landing on the same edge.
               rdat_nxt  = slv_dat_s[ch_r];
               cyc_nxt   = '0;
               stb_nxt   = 1'b0;
               ack_nxt   = 1'b1;
               state_nxt = ST_RESP;
            end
`ifdef WB_ROUTER_TIMEOUT_EN
            else if (cnt_r == 16'(TIMEOUT)) begin
               rdat_nxt  = ERR_DATA;
               cyc_nxt   = '0;
               stb_nxt   = 1'b0;
               ack_nxt   = 1'b1;
               tmo_nxt   = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               cnt_nxt = cnt_r + 16'd1;
            end
`else
            else begin
               state_nxt = ST_FWD;
            end
`endif
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cyc_nxt   = '0;
            stb_nxt   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_r <= ST_IDLE;
         cyc_r   <= '0;
         stb_r   <= 1'b0;
         we_r    <= 1'b0;
         sel_r   <= 4'h0;
         adr_r   <= '0;
         wdat_r  <= '0;
         ack_r   <= 1'b0;
         rdat_r  <= '0;
         tmo_r   <= 1'b0;
         ch_r    <= '0;
         idx_r   <= '0;
`ifdef WB_ROUTER_TIMEOUT_EN
         cnt_r   <= 16'd0;
`endif
      end else begin
         state_r <= state_nxt;
         cyc_r   <= cyc_nxt;
         stb_r   <= stb_nxt;
         we_r    <= we_nxt;
         sel_r   <= sel_nxt;
         adr_r   <= adr_nxt;
         wdat_r  <= wdat_nxt;
         ack_r   <= ack_nxt;
         rdat_r  <= rdat_nxt;
         tmo_r   <= tmo_nxt;
         ch_r    <= ch_nxt;
         idx_r   <= idx_nxt;
`ifdef WB_ROUTER_TIMEOUT_EN
         cnt_r   <= cnt_nxt;
`endif
      end
   end

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = rdat_r;
   assign s_cyc_o   = cyc_r;
   assign s_stb_o   = stb_r;
   assign s_we_o    = we_r;
   assign s_sel_o   = sel_r;
   assign s_adr_o   = adr_r;
   assign s_dat_o   = wdat_r;
   assign timeout_o = tmo_r;

endmodule

// File: tb/tb_wb_addr_router.sv
// Directed bench for wb_addr_router with hand-computed expectations.
// Watchdog scenarios are compiled in when WB_ROUTER_TIMEOUT_EN is defined.
module tb_wb_addr_router;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_ni;
   logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_adr_i, wbs_dat_i;
   logic          wbs_ack_o;
   logic [31:0]   wbs_dat_o;
   logic [3:0]    s_cyc_o;
   logic          s_stb_o, s_we_o;
   logic [3:0]    s_sel_o;
   logic [31:0]   s_adr_o, s_dat_o;
   logic [3:0]    s_ack_i;
   logic [127:0]  s_dat_i;
   logic          timeout_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_addr_router #(
      .N_CH       (4),
      .WIN_BASE   (32'h3000_0000),
      .WIN_BITS   (20),
      .DEBUG_REGS (2),
      .TIMEOUT    (8),
      .ERR_DATA   (32'hDEAD_BEEF)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_sel_o   (s_sel_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_ack_i   (s_ack_i),
      .s_dat_i   (s_dat_i),
      .timeout_o (timeout_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic bus_idle();
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_adr_i = 32'h0000_0000;
      wbs_dat_i = 32'h0000_0000;
   endtask

   task automatic bus_req(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_sel_i = sel;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
   endtask

   // Debug access: ack expected exactly two edges after the request is presented.
   task automatic dbg_access(input string tag, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel,
                             input logic [31:0] exp_rd);
      bus_req(we, adr, dat, sel);
      tick();
      check({tag, "_ack_early"}, {31'd0, wbs_ack_o}, 32'd0);
      check({tag, "_cyc_dbg"}, {28'd0, s_cyc_o}, 32'd0);
      tick();
      check({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd1);
      check({tag, "_cyc_quiet"}, {28'd0, s_cyc_o}, 32'd0);
      if (!we) begin
         check({tag, "_rdata"}, wbs_dat_o, exp_rd);
      end
      bus_idle();
      tick();
      check({tag, "_ack_pulse"}, {31'd0, wbs_ack_o}, 32'd0);
   endtask

   task automatic do_reset();
      wb_rst_ni = 1'b0;
      tick();
      tick();
      wb_rst_ni = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed hang expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      bus_idle();
      s_ack_i = 4'h0;
      s_dat_i = {32'h4444_4444, 32'hCAFE_0002, 32'h1111_1111, 32'h0000_0000};
      wb_rst_ni = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'h0000_0000);
      check("rst_cyc", {28'd0, s_cyc_o}, 32'd0);
      check("rst_stb", {31'd0, s_stb_o}, 32'd0);
      check("rst_adr", s_adr_o, 32'h0000_0000);
      check("rst_tmo", {31'd0, timeout_o}, 32'd0);
      wb_rst_ni = 1'b1;
      tick();

      // Full-word debug write and readback
      dbg_access("dbg0_wr", 1'b1, 32'h300F_FFF8, 32'h1234_5678, 4'hF, 32'h0);
      tick();
      dbg_access("dbg0_rd", 1'b0, 32'h300F_FFF8, 32'h0, 4'hF, 32'h1234_5678);
      tick();

      // Partial byte-enable write after reset
      do_reset();
      tick();
      dbg_access("dbg0_rst_rd", 1'b0, 32'h300F_FFF8, 32'h0, 4'hF, 32'h0000_0000);
      tick();
      dbg_access("dbg1_wr", 1'b1, 32'h300F_FFFC, 32'hAABB_CCDD, 4'b0101, 32'h0);
      tick();
      dbg_access("dbg1_rd", 1'b0, 32'h300F_FFFC, 32'h0, 4'hF, 32'h00BB_00DD);
      tick();

      // Channel 2 read with stray acks on channel 1
      bus_req(1'b0, 32'h3008_0010, 32'h0, 4'hF);
      tick();
      check("ch2_cyc", {28'd0, s_cyc_o}, 32'h0000_0004);
      check("ch2_stb", {31'd0, s_stb_o}, 32'd1);
      check("ch2_adr", s_adr_o, 32'h3008_0010);
      check("ch2_we", {31'd0, s_we_o}, 32'd0);
      s_ack_i = 4'b0010;
      tick();
      check("ch2_stray1", {31'd0, wbs_ack_o}, 32'd0);
      s_ack_i = 4'b0000;
      tick();
      check("ch2_stray2", {31'd0, wbs_ack_o}, 32'd0);
      check("ch2_cyc_hold", {28'd0, s_cyc_o}, 32'h0000_0004);
      s_ack_i = 4'b0100;
      tick();
      check("ch2_ack", {31'd0, wbs_ack_o}, 32'd1);
      check("ch2_rdata", wbs_dat_o, 32'hCAFE_0002);
      check("ch2_cyc_drop", {28'd0, s_cyc_o}, 32'd0);
      check("ch2_stb_drop", {31'd0, s_stb_o}, 32'd0);
      s_ack_i = 4'b0000;
      tick();
      check("ch2_ack_pulse", {31'd0, wbs_ack_o}, 32'd0);
      check("ch2_no_reissue", {28'd0, s_cyc_o}, 32'd0);
      bus_idle();
      tick();
      check("ch2_dat_hold", wbs_dat_o, 32'hCAFE_0002);

      // Outside the window
      bus_req(1'b0, 32'h3100_0000, 32'h0, 4'hF);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("miss_ack", {31'd0, wbs_ack_o}, 32'd0);
         check("miss_cyc", {28'd0, s_cyc_o}, 32'd0);
      end
      bus_idle();
      tick();

`ifdef WB_ROUTER_TIMEOUT_EN
      // Channel 1 never acks: watchdog fires nine edges after s_cyc_o rises
      bus_req(1'b0, 32'h3004_0000, 32'h0, 4'hF);
      tick();
      check("wd_cyc", {28'd0, s_cyc_o}, 32'h0000_0002);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("wd_wait_ack", {31'd0, wbs_ack_o}, 32'd0);
         check("wd_wait_tmo", {31'd0, timeout_o}, 32'd0);
      end
      tick();
      check("wd_ack", {31'd0, wbs_ack_o}, 32'd1);
      check("wd_tmo", {31'd0, timeout_o}, 32'd1);
      check("wd_data", wbs_dat_o, 32'hDEAD_BEEF);
      check("wd_cyc_drop", {28'd0, s_cyc_o}, 32'd0);
      bus_idle();
      tick();
      check("wd_tmo_pulse", {31'd0, timeout_o}, 32'd0);
      tick();

      // Slave ack on the expiry edge wins
      s_dat_i[63:32] = 32'h0BAD_0001;
      bus_req(1'b0, 32'h3004_0000, 32'h0, 4'hF);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
      end
      s_ack_i = 4'b0010;
      tick();
      check("race_ack", {31'd0, wbs_ack_o}, 32'd1);
      check("race_tmo", {31'd0, timeout_o}, 32'd0);
      check("race_data", wbs_dat_o, 32'h0BAD_0001);
      s_ack_i = 4'b0000;
      bus_idle();
      tick();
      tick();
`else
      // Without the watchdog a silent channel stalls until the master gives up
      bus_req(1'b0, 32'h3004_0000, 32'h0, 4'hF);
      tick();
      check("stall_cyc", {28'd0, s_cyc_o}, 32'h0000_0002);
      for (int i = 0; i < 30; i++) begin
         tick();
         check("stall_ack", {31'd0, wbs_ack_o}, 32'd0);
         check("stall_tmo", {31'd0, timeout_o}, 32'd0);
      end
      check("stall_cyc_hold", {28'd0, s_cyc_o}, 32'h0000_0002);
      bus_idle();
      tick();
      check("stall_abort_cyc", {28'd0, s_cyc_o}, 32'd0);
      tick();
`endif

      // Reset during a forwarded transfer
      bus_req(1'b0, 32'h300C_0000, 32'h0, 4'hF);
      tick();
      check("rfwd_cyc", {28'd0, s_cyc_o}, 32'h0000_0008);
      wb_rst_ni = 1'b0;
      tick();
      check("rfwd_cyc_clr", {28'd0, s_cyc_o}, 32'd0);
      check("rfwd_stb_clr", {31'd0, s_stb_o}, 32'd0);
      check("rfwd_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rfwd_dat_clr", wbs_dat_o, 32'h0000_0000);
      check("rfwd_adr_clr", s_adr_o, 32'h0000_0000);
      wb_rst_ni = 1'b1;
      bus_idle();
      tick();

      // Master abort during a forwarded transfer
      bus_req(1'b1, 32'h3000_0000, 32'h5555_AAAA, 4'hF);
      tick();
      check("abort_cyc", {28'd0, s_cyc_o}, 32'h0000_0001);
      check("abort_sdat", s_dat_o, 32'h5555_AAAA);
      bus_idle();
      tick();
      check("abort_cyc_clr", {28'd0, s_cyc_o}, 32'd0);
      check("abort_stb_clr", {31'd0, s_stb_o}, 32'd0);
      check("abort_ack", {31'd0, wbs_ack_o}, 32'd0);
      tick();
      check("abort_ack_late", {31'd0, wbs_ack_o}, 32'd0);

      // Debug access after abort, then an aborted debug write must not land
      dbg_access("post_wr", 1'b1, 32'h300F_FFF8, 32'h5A5A_A5A5, 4'hF, 32'h0);
      tick();
      bus_req(1'b1, 32'h300F_FFF8, 32'hFFFF_FFFF, 4'hF);
      tick();
      bus_idle();
      tick();
      check("dabort_ack", {31'd0, wbs_ack_o}, 32'd0);
      tick();
      check("dabort_ack_late", {31'd0, wbs_ack_o}, 32'd0);
      dbg_access("post_rd", 1'b0, 32'h300F_FFF8, 32'h0, 4'hF, 32'h5A5A_A5A5);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_addr_router.md
Name: wb_addr_router

Overview:
- Parametrised Wishbone address router for the user project area; the successor to the fixed two-way user/debug split.
- Decodes one Wishbone slave port into N_CH user slave channels plus an internal bank of DEBUG_REGS debug registers at the top of the window.
- Registered handshakes, with an optional bus-timeout watchdog.
- Instantiated inside user_project_wrapper between the management-side Wishbone port and the user slaves.

Parameters:
- N_CH, 4: number of user slave channels; power of 2, 1..16.
- WIN_BASE, 32'h3000_0000: window base; only bits [31:WIN_BITS] are compared.
- WIN_BITS, 20: log2 of window size in bytes.
- DEBUG_REGS, 2: debug register count; power of 2, 2..16.
- TIMEOUT, 255: watchdog limit in cycles, 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset
- wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  master request
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- s_cyc_o  out  N_CH  per-channel cycle
- s_stb_o / s_we_o  out  1 each  shared strobe / write enable
- s_sel_o  out  4  shared byte enables
- s_adr_o / s_dat_o  out  32 each  shared address / write data
- s_ack_i  in  N_CH  per-channel ack
- s_dat_i  in  32*N_CH  per-channel read data, channel k at [32k+31:32k]
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_ni is synchronous and active-low.
- Reset values: all outputs 0, debug registers 0, FSM in IDLE, watchdog counter 0. A reset asserted mid-transaction clears state at that edge; no ack is issued.
- Window hit: wbs_adr_i[31:WIN_BITS] == WIN_BASE[31:WIN_BITS]. Misses are ignored: no ack, no s_cyc_o.
- Debug hit: window hit AND adr[WIN_BITS-1:2+DBG_AW] all ones, where DBG_AW = log2(DEBUG_REGS). Index = adr[2+DBG_AW-1:2]. Debug hits take priority over the channel decode.
- Channel index: adr[WIN_BITS-1 -: CH_W], where CH_W = log2(N_CH); N_CH = 1 means channel 0.
- Defaults map: ch0 0x3000_0000; ch3 0x300C_0000–0x300F_FFF7; debug 0x300F_FFF8 (idx0) and 0x300F_FFFC (idx1).
- s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o are registered copies latched at request acceptance.
- FSM states: IDLE, DBG, FWD, RESP.
  - IDLE: on cyc&stb&window hit, latch the request. Go to DBG on a debug hit; otherwise go to FWD with s_cyc_o[ch] = 1 and s_stb_o = 1.
  - DBG: a write updates bytes per wbs_sel_i. A read loads the register into wbs_dat_o. Assert wbs_ack_o, then go to RESP. Latency: request at cycle 0 → ack at cycle 2.
  - FWD: wait for s_ack_i[ch]. On ack, capture s_dat_i[ch] into wbs_dat_o, drop s_cyc_o and s_stb_o, assert wbs_ack_o, go to RESP. Slave ack at cycle k → wbs_ack_o at cycle k+1. Acks on non-selected channels are ignored.
  - RESP: deassert wbs_ack_o (exactly one-cycle pulse). Return to IDLE even if wbs_stb_i is still high. A new request is accepted one cycle later at the earliest.
- Abort: wbs_cyc_i low in FWD or DBG → IDLE next edge, s_cyc_o cleared, no ack, debug write suppressed.
- Simultaneous slave ack and watchdog expiry: the ack wins; no timeout_o.
- wbs_dat_o holds its last value between transactions.

Optional Feature:
- Macro: WB_ROUTER_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to FWD and increments each FWD cycle. When it equals TIMEOUT: drop s_cyc_o, set wbs_dat_o = ERR_DATA, pulse wbs_ack_o and timeout_o together, go to RESP.
- Undefined: FWD waits indefinitely; timeout_o is tied to 0; no counter logic is present.

Decomposition:
- Package wb_router_pkg: state enum (IDLE/DBG/FWD/RESP), the clog2 helper, default ERR_DATA, and the WB data/address width constants (32).
- Sub-module wb_router_dbg_regs: debug register bank with byte-enable write and indexed read.
- Decode, FSM and watchdog stay in the top module.

Test Plan:
- Write 32'h1234_5678, sel 4'hF, to 0x300F_FFF8, then read it back → ack 2 cycles after each request; readback 32'h1234_5678; s_cyc_o stays 0.
- Write 32'hAABB_CCDD with sel 4'b0101 to 0x300F_FFFC after reset → readback 32'h00BB_00DD.
- Read 0x3008_0010; ch2 acks 3 cycles after its s_cyc_o rises with 32'hCAFE_0002 → s_cyc_o = 4'b0100, s_adr_o = 0x3008_0010, wbs_dat_o = 32'hCAFE_0002, one-cycle ack; stray s_ack_i[1] pulses are ignored.
- Read 0x3100_0000 (outside window) → no ack, s_cyc_o = 0 for 20 cycles.
- With WB_ROUTER_TIMEOUT_EN, TIMEOUT = 8, ch1 never acks → ack and timeout_o 9 cycles after s_cyc_o rises; data 32'hDEAD_BEEF. Ack and timeout on the same cycle → normal data, no timeout_o.
- Reset pulled low during FWD, then a master drop of wbs_cyc_i in a separate FWD → all outputs 0 next edge with no ack; the next debug access works normally.
